corr_stim_sequencer: RTL and testbench

//  Synthesisable stimulus sequencer for power/EM correlation runs. Drives the DUT input bus

---
 rtl/corr_pkg.sv | 14 +
 rtl/corr_lfsr32.sv | 19 +
 rtl/corr_stim_sequencer.sv | 99 +++++++++
 tb/tb_corr_stim_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// corr_pkg: shared state encoding, mode codes and LFSR helpers for the correlation stimulus sequencer
package corr_pkg;
    localparam int LFSR_W = 32;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic MODE_EXH = 1'b0;
    localparam logic MODE_RND = 1'b1;
    typedef enum logic [1:0] {IDLE, PH_A, PH_B, FIN} state_t;
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction
    function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] s);
        return (s == '0) ? LFSR_W'(1) : s;
    endfunction
endpackage

// File: rtl/corr_lfsr32.sv
// corr_lfsr32: 32-bit Galois LFSR with seed load and zero-seed guard
module corr_lfsr32 import corr_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);
    logic [LFSR_W-1:0] base;
    assign base = load ? lfsr_seed(seed) : q;
    // a load with step set lands on the first stepped value, not the seed itself
    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= LFSR_W'(1);
        else if (load || step)
            q <= step ? lfsr_step(base) : base;
    end
endmodule

// File: rtl/corr_stim_sequencer.sv
// corr_stim_sequencer: emits ordered A/B vector pairs (exhaustive or LFSR-random) with trigger and pair index
module corr_stim_sequencer import corr_pkg::*; #(
    parameter int IN_SIZE     = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int N_PAIRS     = 64,
    parameter int IDX_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic               mode,
    input  logic [LFSR_W-1:0]  seed,
    output logic [IN_SIZE-1:0] stim,
    output logic               trig,
    output logic [IDX_W-1:0]   sim_idx,
    output logic               busy,
    output logic               done
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    state_t state, state_nx;
    logic [HW-1:0] hcnt;
    logic [IN_SIZE-1:0] i, j, i_nx, vec, stim_nx;
    logic [LFSR_W-1:0] lq, lnx;
    logic mode_r, active, start_ok, adv, last_pair, load_a, load_b;
    logic trig_nx, busy_nx, done_nx, unused_lnx;

    corr_lfsr32 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_ok),
        .seed  (seed),
        .step  (load_a || load_b),
        .q     (lq)
    );

    assign active    = state == PH_A || state == PH_B;
    assign start_ok  = state == IDLE && start && !abort;
    assign adv       = active && !abort && !pause && hcnt == HW'(HOLD_CYCLES - 1);
    assign last_pair = (mode_r == MODE_RND) ? sim_idx == IDX_W'(N_PAIRS - 1) : &{i, j};
    assign load_a    = start_ok || (state == PH_B && adv && !last_pair);
    assign load_b    = state == PH_A && adv;
    assign i_nx      = (&j) ? i + IN_SIZE'(1) : i;
    // mirrors the LFSR's own next value so the vector register loads in step with it
    assign lnx        = lfsr_step(start_ok ? lfsr_seed(seed) : lq);
    assign unused_lnx = ^lnx;
    assign vec = ((start_ok ? mode : mode_r) == MODE_RND) ? lnx[IN_SIZE-1:0] :
                 start_ok ? '0 : load_b ? j : i_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            hcnt    <= '0;
            i       <= '0;
            j       <= '0;
            mode_r  <= MODE_EXH;
            sim_idx <= '0;
            stim    <= '0;
            trig    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nx;
            hcnt  <= (!active || abort || adv) ? '0 : pause ? hcnt : hcnt + HW'(1);
            stim  <= stim_nx;
            trig  <= trig_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            if (start_ok) begin
                mode_r  <= mode;
                i       <= '0;
                j       <= '0;
                sim_idx <= '0;
            end else if (load_a) begin
                i       <= i_nx;
                j       <= j + IN_SIZE'(1);
                sim_idx <= sim_idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start_ok ? PH_A : IDLE;
            PH_A:    state_nx = abort ? IDLE : adv ? PH_B : PH_A;
            PH_B:    state_nx = abort ? IDLE : adv ? (last_pair ? FIN : PH_A) : PH_B;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy_nx = state_nx == PH_A || state_nx == PH_B;
        trig_nx = state_nx == PH_B;
        done_nx = state_nx == FIN;
        stim_nx = (load_a || load_b) ? vec : busy_nx ? stim : '0;
    end
endmodule

// File: tb/tb_corr_stim_sequencer.sv
// tb_corr_stim_sequencer: directed checks of exhaustive, random, pause, abort, restart and reset behaviour
module tb_corr_stim_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0, start_a = 1'b0, start_b = 1'b0, abort = 1'b0, pause = 1'b0, mode = 1'b0;
    logic [31:0] seed = '0;
    logic [1:0] stim_a, stim_b;
    logic trig_a, busy_a, done_a, trig_b, busy_b, done_b;
    logic [15:0] idx_a, idx_b;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    corr_stim_sequencer #(.IN_SIZE(2), .HOLD_CYCLES(1), .N_PAIRS(3), .IDX_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .pause(pause), .mode(mode),
        .seed(seed), .stim(stim_a), .trig(trig_a), .sim_idx(idx_a), .busy(busy_a), .done(done_a)
    );

    corr_stim_sequencer #(.IN_SIZE(2), .HOLD_CYCLES(3), .N_PAIRS(3), .IDX_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .pause(pause), .mode(mode),
        .seed(seed), .stim(stim_b), .trig(trig_b), .sim_idx(idx_b), .busy(busy_b), .done(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int s, input int t, input int ix, input int b, input int d);
        chk({tag, "_stim"}, 32'(stim_a), s);
        chk({tag, "_trig"}, 32'(trig_a), t);
        chk({tag, "_idx"}, 32'(idx_a), ix);
        chk({tag, "_busy"}, 32'(busy_a), b);
        chk({tag, "_done"}, 32'(done_a), d);
    endtask

    // full 16-pair exhaustive run on dut_a; restart pulses start mid-run and in FIN
    task automatic run_exh(input string tag, input bit restart);
        mode = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            int p = (c - 1) / 2;
            chk_a(tag, (c % 2 == 1) ? p / 4 : p % 4, (c % 2 == 0) ? 1 : 0, p, 1, 0);
            start_a = restart && (c == 5 || c == 20);
            tick();
        end
        chk_a({tag, "_fin"}, 0, 0, 15, 0, 1);
        start_a = restart;
        tick();
        start_a = 1'b0;
        chk_a({tag, "_post"}, 0, 0, 15, 0, 0);
        tick();
        chk_a({tag, "_idle"}, 0, 0, 15, 0, 0);
    endtask

    task automatic run_rnd(input string tag, input logic [31:0] sd);
        logic [1:0] exp_v [6];
        exp_v = '{2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1};
        mode = 1'b1;
        seed = sd;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk_a(tag, 32'(exp_v[c - 1]), (c % 2 == 0) ? 1 : 0, (c - 1) / 2, 1, 0);
            tick();
        end
        chk_a({tag, "_fin"}, 0, 0, 2, 0, 1);
        tick();
        mode = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk_a("reset", 0, 0, 0, 0, 0);
        chk("reset_b_busy", 32'(busy_b), 0);
        rst_n = 1'b1;
        tick();

        run_exh("exh", 1'b0);

        run_rnd("rnd_s0", 32'h0);
        run_rnd("rnd_s1", 32'h1);

        // pause two cycles during PH_A of pair 0 with HOLD=3
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        pause = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (c == 3) pause = 1'b0;
            chk("pause_trig", 32'(trig_b), (c >= 6 && c <= 8) || c >= 12);
            chk("pause_idx", 32'(idx_b), (c <= 8) ? 0 : 1);
            chk("pause_busy", 32'(busy_b), 1);
            if (c == 12) chk("pause_b1", 32'(stim_b), 1);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("pause_abort_busy", 32'(busy_b), 0);
        tick();

        // abort in the 2nd cycle of PH_B of pair 5
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        repeat (34) tick();
        chk("abort_pre_stim", 32'(stim_b), 1);
        chk("abort_pre_trig", 32'(trig_b), 1);
        chk("abort_pre_idx", 32'(idx_b), 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("abort_stim", 32'(stim_b), 0);
            chk("abort_trig", 32'(trig_b), 0);
            chk("abort_busy", 32'(busy_b), 0);
            chk("abort_done", 32'(done_b), 0);
            chk("abort_idx", 32'(idx_b), 5);
            tick();
        end

        run_exh("restart", 1'b1);

        start_a = 1'b1;
        abort = 1'b1;
        tick();
        start_a = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_a("start_abort", 0, 0, 15, 0, 0);
            tick();
        end

        // reset for one cycle mid-PH_A, then a fresh run
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        chk("mid_rst_pre_stim", 32'(stim_a), 0);
        chk("mid_rst_pre_idx", 32'(idx_a), 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_a("mid_rst", 0, 0, 0, 0, 0);
        tick();
        chk_a("mid_rst_idle", 0, 0, 0, 0, 0);
        run_exh("after_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
